execute_mc: RTL and testbench
=============================

Name: execute_mc

Overview:
Parametrised execute stage for the light RV32I pipeline that supersedes the single-cycle EX stage. Same ALU/branch-target datapath, plus:
- a valid/stall/flush pipeline handshake;
- an iterative multi-cycle multiplier (RV32M MUL/MULH/MULHU) driven by a small FSM.
Sits between the ID/EX register and the MEM stage; the EX/MEM register is internal to this block.

Parameters:
XLEN, 32, datapath width.
REG_ADDR_W, 5, register index width.
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per cycle; legal values 1, 2, 4 and must divide XLEN; N = XLEN/MUL_BITS_PER_CYCLE.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous active-high reset.
i_valid  in  1  ID/EX holds a valid instruction.
o_ready  out  1  stage can accept this cycle.
i_stall  in  1  downstream stall; EX/MEM register holds.
i_flush  in  1  kill in-flight and incoming instruction.
i_pipe_PC, i_pipe_Imm, i_pipe_Reg1Data, i_pipe_Reg2Data  in  XLEN each  operands.
i_pipe_RegDst  in  REG_ADDR_W  destination register.
i_pipe_Alu1Src  in  1  ALU A select: 1=PC, 0=Reg1.
i_pipe_Alu2Src  in  2  ALU B select: IMM, REG2, FOUR, else 0 (codebase encodings).
i_pipe_AluCtr  in  4  ALU operation (codebase encodings).
i_pipe_MulEn  in  1  instruction is a multiply; AluCtr ignored.
i_pipe_MulOp  in  2  bit0=return high half, bit1=signed operands.
i_pipe_MemToReg, i_pipe_RegWrEn, i_pipe_MemWrEn, i_pipe_Branch, i_pipe_Jump  in  1 each  controls.
o_valid  out  1  EX/MEM register holds a valid instruction.
o_pipe_TargetAddr, o_pipe_AluResult, o_pipe_Reg2Data  out  XLEN each  results.
o_pipe_Zero  out  1  result == 0.
o_pipe_RegDst  out  REG_ADDR_W  passed through.
o_pipe_MemToReg, o_pipe_RegWrEn, o_pipe_MemWrEn, o_pipe_Branch, o_pipe_Jump  out  1 each  passed through.

Behaviour:
- Reset: every output 0, FSM to IDLE, counter and product 0. Applies immediately, including mid-multiply; the partial result is discarded.
- o_ready = (state==IDLE) & ~i_stall. An instruction is accepted on a rising edge with i_valid & o_ready & ~i_flush.
- Non-multiply: on acceptance, EX/MEM is loaded with the ALU result, zero flag, PC+Imm and pass-through fields; o_valid=1. Latency is 1 cycle.
- Edge with no acceptance and ~i_stall: o_valid<=0 and RegWrEn/MemWrEn/Branch/Jump are cleared (bubble); data fields may hold.
- i_stall=1: every EX/MEM output holds its value, and the FSM does not leave DONE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on accepting MulEn=1. Operands, controls and PC+Imm are latched, and o_valid<=0 on that edge.
  - BUSY: on each edge, MUL_BITS_PER_CYCLE multiplier bits are shift-added into a 2*XLEN accumulator and the counter decrements from N. At count 0 the FSM moves to DONE.
  - DONE -> IDLE on the first edge with ~i_stall. EX/MEM is loaded with the selected product half, Zero, and the latched fields; o_valid=1.
  - For N=32, o_valid rises at acceptance edge + N + 1.
- Signed multiply: multiply operand magnitudes unsigned, then negate the 2*XLEN product if the operand signs differ. MulOp=10 is MUL-signed low; this equals unsigned low.
- i_flush: takes priority over acceptance. FSM -> IDLE and any multiply is aborted. On the same edge o_valid<=0 and controls are cleared, regardless of i_stall.
- Simultaneous i_valid and flush: the incoming instruction is dropped.
- All arithmetic is modulo 2^XLEN. Zero refers to the written result.

Optional Feature:
EXEC_FWD_EN
- Defined: adds ports i_pipe_Rs1, i_pipe_Rs2 (REG_ADDR_W); i_fwd_MemRegDst/i_fwd_MemRegWrEn/i_fwd_MemData; and i_fwd_WbRegDst/i_fwd_WbRegWrEn/i_fwd_WbData.
  - Each register operand, including Reg2Data pass-through, takes MEM data if RegWrEn is set and Dst==Rs, else WB data if RegWrEn is set and Dst==Rs, else ID/EX data.
  - Register 0 is never forwarded.
  - Multiply operands are forwarded, then latched at acceptance.
- Undefined: these ports do not exist and ID/EX data is used directly.

Test Plan:
- ADD, Reg1=5, Reg2=7, Alu2Src=REG2, valid -> next edge o_valid=1, AluResult=12, Zero=0. Idle cycle after -> o_valid=0, RegWrEn=0.
- MULHU 0xFFFFFFFF*0xFFFFFFFF, K=1 -> o_ready=0 for 33 cycles. o_valid=1 at acceptance+33 with AluResult=0xFFFFFFFE; MUL low of the same operands gives 0x00000001.
- MULH signed -3*4 -> AluResult=0xFFFFFFFF; MUL low -> 0xFFFFFFF4; Zero=0. Repeat with K=4: result valid at acceptance+9.
- Stall held 3 cycles while multiply reaches DONE -> outputs frozen, o_ready=0. Result appears on the first edge after stall drops.
- Flush at BUSY count 10 -> o_valid=0, o_ready=1 next cycle, no result emitted. Reset mid-multiply -> all outputs 0 immediately.
- EXEC_FWD_EN: Rs1=3 with MEM and WB both writing x3 (0xAA, 0xBB) -> MEM value used. Rs1=0 with MEM writing x0 -> ID/EX value used.

Source files
------------

// File: rtl/execute_mc.sv
// Execute stage for the light RV32I pipeline: ALU/branch-target datapath, EX/MEM register,
// valid/stall/flush handshake and an iterative shift-add multiplier. Define EXEC_FWD_EN to add MEM/WB forwarding.
module execute_mc #(
  parameter int XLEN               = 32,
  parameter int REG_ADDR_W         = 5,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [XLEN-1:0]       i_pipe_PC,
  input  logic [XLEN-1:0]       i_pipe_Imm,
  input  logic [XLEN-1:0]       i_pipe_Reg1Data,
  input  logic [XLEN-1:0]       i_pipe_Reg2Data,
  input  logic [REG_ADDR_W-1:0] i_pipe_RegDst,
  input  logic                  i_pipe_Alu1Src,
  input  logic [1:0]            i_pipe_Alu2Src,
  input  logic [3:0]            i_pipe_AluCtr,
  input  logic                  i_pipe_MulEn,
  input  logic [1:0]            i_pipe_MulOp,
  input  logic                  i_pipe_MemToReg,
  input  logic                  i_pipe_RegWrEn,
  input  logic                  i_pipe_MemWrEn,
  input  logic                  i_pipe_Branch,
  input  logic                  i_pipe_Jump,
  output logic                  o_valid,
  output logic [XLEN-1:0]       o_pipe_TargetAddr,
  output logic [XLEN-1:0]       o_pipe_AluResult,
  output logic [XLEN-1:0]       o_pipe_Reg2Data,
  output logic                  o_pipe_Zero,
  output logic [REG_ADDR_W-1:0] o_pipe_RegDst,
  output logic                  o_pipe_MemToReg,
  output logic                  o_pipe_RegWrEn,
  output logic                  o_pipe_MemWrEn,
  output logic                  o_pipe_Branch,
  output logic                  o_pipe_Jump
`ifdef EXEC_FWD_EN
  ,
  input  logic [REG_ADDR_W-1:0] i_pipe_Rs1,
  input  logic [REG_ADDR_W-1:0] i_pipe_Rs2,
  input  logic [REG_ADDR_W-1:0] i_fwd_MemRegDst,
  input  logic                  i_fwd_MemRegWrEn,
  input  logic [XLEN-1:0]       i_fwd_MemData,
  input  logic [REG_ADDR_W-1:0] i_fwd_WbRegDst,
  input  logic                  i_fwd_WbRegWrEn,
  input  logic [XLEN-1:0]       i_fwd_WbData
`endif
);
  localparam int K     = MUL_BITS_PER_CYCLE;
  localparam int N     = XLEN / K;
  localparam int CNT_W = $clog2(N + 1);
  localparam int SH_W  = $clog2(XLEN);

  localparam logic [1:0] SRC2_IMM  = 2'd0;
  localparam logic [1:0] SRC2_REG2 = 2'd1;
  localparam logic [1:0] SRC2_FOUR = 2'd2;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_LUI  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  if (!(K == 1 || K == 2 || K == 4) || (XLEN % K) != 0) begin : g_bad_k
    $error("MUL_BITS_PER_CYCLE must be 1, 2 or 4 and divide XLEN");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       target;
    logic [XLEN-1:0]       alu;
    logic [XLEN-1:0]       reg2;
    logic                  zero;
    logic [REG_ADDR_W-1:0] regdst;
    logic                  memtoreg;
    logic                  regwr;
    logic                  memwr;
    logic                  branch;
    logic                  jump;
  } exmem_t;

  function automatic logic [XLEN-1:0] alu_f(input logic [3:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [SH_W-1:0] sh;
    sh = b[SH_W-1:0];
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_SLL:  return a << sh;
      ALU_SLT:  return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: return {{(XLEN-1){1'b0}}, a < b};
      ALU_XOR:  return a ^ b;
      ALU_SRL:  return a >> sh;
      ALU_SRA:  return $unsigned($signed(a) >>> sh);
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_LUI:  return b;
      default:  return '0;
    endcase
  endfunction

  logic [XLEN-1:0] rs1_data, rs2_data;
`ifdef EXEC_FWD_EN
  // MEM is younger than WB, so it wins; x0 is hardwired and never forwarded.
  assign rs1_data = (i_pipe_Rs1 != '0 && i_fwd_MemRegWrEn && i_fwd_MemRegDst == i_pipe_Rs1) ? i_fwd_MemData :
                    (i_pipe_Rs1 != '0 && i_fwd_WbRegWrEn  && i_fwd_WbRegDst  == i_pipe_Rs1) ? i_fwd_WbData  :
                    i_pipe_Reg1Data;
  assign rs2_data = (i_pipe_Rs2 != '0 && i_fwd_MemRegWrEn && i_fwd_MemRegDst == i_pipe_Rs2) ? i_fwd_MemData :
                    (i_pipe_Rs2 != '0 && i_fwd_WbRegWrEn  && i_fwd_WbRegDst  == i_pipe_Rs2) ? i_fwd_WbData  :
                    i_pipe_Reg2Data;
`else
  assign rs1_data = i_pipe_Reg1Data;
  assign rs2_data = i_pipe_Reg2Data;
`endif

  state_t                state_q, state_d;
  exmem_t                ex_q, ex_d, ctx_q, ctx_d, in_fields;
  logic                  mul_hi_q, mul_hi_d, mul_neg_q, mul_neg_d;
  logic [2*XLEN-1:0]     acc_q, acc_d, mcand_q, mcand_d, prod_s;
  logic [XLEN-1:0]       mplier_q, mplier_d, alu_a, alu_b, alu_y, a_mag, b_mag, mul_res;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  accept, a_neg, b_neg;

  assign o_ready = (state_q == S_IDLE) & ~i_stall;
  assign accept  = i_valid & o_ready & ~i_flush;

  always_comb begin
    alu_a = i_pipe_Alu1Src ? i_pipe_PC : rs1_data;
    case (i_pipe_Alu2Src)
      SRC2_IMM:  alu_b = i_pipe_Imm;
      SRC2_REG2: alu_b = rs2_data;
      SRC2_FOUR: alu_b = XLEN'(4);
      default:   alu_b = '0;
    endcase
    alu_y = alu_f(i_pipe_AluCtr, alu_a, alu_b);

    in_fields          = '0;
    in_fields.valid    = 1'b1;
    in_fields.target   = i_pipe_PC + i_pipe_Imm;
    in_fields.alu      = alu_y;
    in_fields.reg2     = rs2_data;
    in_fields.zero     = (alu_y == '0);
    in_fields.regdst   = i_pipe_RegDst;
    in_fields.memtoreg = i_pipe_MemToReg;
    in_fields.regwr    = i_pipe_RegWrEn;
    in_fields.memwr    = i_pipe_MemWrEn;
    in_fields.branch   = i_pipe_Branch;
    in_fields.jump     = i_pipe_Jump;

    // Signed multiply works on magnitudes and fixes the sign of the full product at the end.
    a_neg   = i_pipe_MulOp[1] & rs1_data[XLEN-1];
    b_neg   = i_pipe_MulOp[1] & rs2_data[XLEN-1];
    a_mag   = a_neg ? -rs1_data : rs1_data;
    b_mag   = b_neg ? -rs2_data : rs2_data;
    prod_s  = mul_neg_q ? -acc_q : acc_q;
    mul_res = mul_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  end

  always_comb begin
    state_d   = state_q;
    ex_d      = ex_q;
    ctx_d     = ctx_q;
    mul_hi_d  = mul_hi_q;
    mul_neg_d = mul_neg_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;

    if (!i_stall) begin
      ex_d.valid  = 1'b0;
      ex_d.regwr  = 1'b0;
      ex_d.memwr  = 1'b0;
      ex_d.branch = 1'b0;
      ex_d.jump   = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept && i_pipe_MulEn) begin
          state_d   = S_BUSY;
          ctx_d     = in_fields;
          mul_hi_d  = i_pipe_MulOp[0];
          mul_neg_d = a_neg ^ b_neg;
          acc_d     = '0;
          mcand_d   = {{XLEN{1'b0}}, a_mag};
          mplier_d  = b_mag;
          cnt_d     = CNT_W'(N);
        end else if (accept) begin
          ex_d = in_fields;
        end
      end
      S_BUSY: begin
        acc_d    = acc_q + (mcand_q * {{(2*XLEN-K){1'b0}}, mplier_q[K-1:0]});
        mcand_d  = mcand_q << K;
        mplier_d = mplier_q >> K;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!i_stall) begin
          state_d    = S_IDLE;
          ex_d       = ctx_q;
          ex_d.valid = 1'b1;
          ex_d.alu   = mul_res;
          ex_d.zero  = (mul_res == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (i_flush) begin
      state_d     = S_IDLE;
      ex_d.valid  = 1'b0;
      ex_d.regwr  = 1'b0;
      ex_d.memwr  = 1'b0;
      ex_d.branch = 1'b0;
      ex_d.jump   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ex_q      <= '0;
      ctx_q     <= '0;
      mul_hi_q  <= 1'b0;
      mul_neg_q <= 1'b0;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ex_q      <= ex_d;
      ctx_q     <= ctx_d;
      mul_hi_q  <= mul_hi_d;
      mul_neg_q <= mul_neg_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_valid           = ex_q.valid;
  assign o_pipe_TargetAddr = ex_q.target;
  assign o_pipe_AluResult  = ex_q.alu;
  assign o_pipe_Reg2Data   = ex_q.reg2;
  assign o_pipe_Zero       = ex_q.zero;
  assign o_pipe_RegDst     = ex_q.regdst;
  assign o_pipe_MemToReg   = ex_q.memtoreg;
  assign o_pipe_RegWrEn    = ex_q.regwr;
  assign o_pipe_MemWrEn    = ex_q.memwr;
  assign o_pipe_Branch     = ex_q.branch;
  assign o_pipe_Jump       = ex_q.jump;
endmodule

// File: tb/tb_execute_mc.sv
// Directed bench for execute_mc: two instances (1 and 4 multiplier bits per cycle) share stimulus.
module tb_execute_mc;
  localparam logic [1:0] SRC2_IMM = 2'd0, SRC2_REG2 = 2'd1, SRC2_FOUR = 2'd2;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SLT = 4'b0010, ALU_SUB = 4'b1000, ALU_SRA = 4'b1101;

  logic        clk = 1'b0, reset = 1'b1;
  logic        i_valid, i_stall, i_flush;
  logic [31:0] pc, imm, r1, r2;
  logic [4:0]  regdst;
  logic        a1src, mulen, memtoreg, regwr, memwr, branch, jump;
  logic [1:0]  a2src, mulop;
  logic [3:0]  aluctr;
`ifdef EXEC_FWD_EN
  logic [4:0]  rs1, rs2, mem_dst, wb_dst;
  logic        mem_we, wb_we;
  logic [31:0] mem_data, wb_data;
`endif

  logic        rdy1, v1, z1, mtr1, rw1, mw1, br1, jp1;
  logic [31:0] tgt1, alu1, r2o1;
  logic [4:0]  rd1;
  logic        rdy4, v4, z4, mtr4, rw4, mw4, br4, jp4;
  logic [31:0] tgt4, alu4, r2o4;
  logic [4:0]  rd4;

  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  execute_mc #(.XLEN(32), .REG_ADDR_W(5), .MUL_BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(rdy1), .i_stall(i_stall), .i_flush(i_flush),
    .i_pipe_PC(pc), .i_pipe_Imm(imm), .i_pipe_Reg1Data(r1), .i_pipe_Reg2Data(r2), .i_pipe_RegDst(regdst),
    .i_pipe_Alu1Src(a1src), .i_pipe_Alu2Src(a2src), .i_pipe_AluCtr(aluctr), .i_pipe_MulEn(mulen),
    .i_pipe_MulOp(mulop), .i_pipe_MemToReg(memtoreg), .i_pipe_RegWrEn(regwr), .i_pipe_MemWrEn(memwr),
    .i_pipe_Branch(branch), .i_pipe_Jump(jump), .o_valid(v1), .o_pipe_TargetAddr(tgt1),
    .o_pipe_AluResult(alu1), .o_pipe_Reg2Data(r2o1), .o_pipe_Zero(z1), .o_pipe_RegDst(rd1),
    .o_pipe_MemToReg(mtr1), .o_pipe_RegWrEn(rw1), .o_pipe_MemWrEn(mw1), .o_pipe_Branch(br1),
    .o_pipe_Jump(jp1)
`ifdef EXEC_FWD_EN
    , .i_pipe_Rs1(rs1), .i_pipe_Rs2(rs2), .i_fwd_MemRegDst(mem_dst), .i_fwd_MemRegWrEn(mem_we),
    .i_fwd_MemData(mem_data), .i_fwd_WbRegDst(wb_dst), .i_fwd_WbRegWrEn(wb_we), .i_fwd_WbData(wb_data)
`endif
  );

  execute_mc #(.XLEN(32), .REG_ADDR_W(5), .MUL_BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(rdy4), .i_stall(i_stall), .i_flush(i_flush),
    .i_pipe_PC(pc), .i_pipe_Imm(imm), .i_pipe_Reg1Data(r1), .i_pipe_Reg2Data(r2), .i_pipe_RegDst(regdst),
    .i_pipe_Alu1Src(a1src), .i_pipe_Alu2Src(a2src), .i_pipe_AluCtr(aluctr), .i_pipe_MulEn(mulen),
    .i_pipe_MulOp(mulop), .i_pipe_MemToReg(memtoreg), .i_pipe_RegWrEn(regwr), .i_pipe_MemWrEn(memwr),
    .i_pipe_Branch(branch), .i_pipe_Jump(jump), .o_valid(v4), .o_pipe_TargetAddr(tgt4),
    .o_pipe_AluResult(alu4), .o_pipe_Reg2Data(r2o4), .o_pipe_Zero(z4), .o_pipe_RegDst(rd4),
    .o_pipe_MemToReg(mtr4), .o_pipe_RegWrEn(rw4), .o_pipe_MemWrEn(mw4), .o_pipe_Branch(br4),
    .o_pipe_Jump(jp4)
`ifdef EXEC_FWD_EN
    , .i_pipe_Rs1(rs1), .i_pipe_Rs2(rs2), .i_fwd_MemRegDst(mem_dst), .i_fwd_MemRegWrEn(mem_we),
    .i_fwd_MemData(mem_data), .i_fwd_WbRegDst(wb_dst), .i_fwd_WbRegWrEn(wb_we), .i_fwd_WbData(wb_data)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    i_valid = 0; i_stall = 0; i_flush = 0; pc = 0; imm = 0; r1 = 0; r2 = 0; regdst = 0;
    a1src = 0; a2src = SRC2_IMM; aluctr = ALU_ADD; mulen = 0; mulop = 0;
    memtoreg = 0; regwr = 0; memwr = 0; branch = 0; jump = 0;
`ifdef EXEC_FWD_EN
    rs1 = 0; rs2 = 0; mem_dst = 0; wb_dst = 0; mem_we = 0; wb_we = 0; mem_data = 0; wb_data = 0;
`endif
  endtask

  task automatic alu_op(input logic [3:0] op, input logic s1, input logic [1:0] s2,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    clear_in();
    i_valid = 1; aluctr = op; a1src = s1; a2src = s2; r1 = a; r2 = b; imm = im;
    pc = 32'h100; regwr = 1; regdst = 5'd9;
  endtask

  // Accept a multiply, then watch both instances for the full 1-bit latency.
  task automatic mul_test(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp);
    int bad;
    bad = 0;
    clear_in();
    i_valid = 1; mulen = 1; mulop = op; r1 = a; r2 = b; regwr = 1; regdst = 5'd7;
    pc = 32'h200; imm = 32'h10; aluctr = ALU_SUB;
    step();
    i_valid = 0; mulen = 0;
    check({tag, " accept v1"}, v1, 1'b0);
    check({tag, " accept rdy1"}, rdy1, 1'b0);
    for (int e = 1; e <= 33; e++) begin
      step();
      if (e <= 32 && (rdy1 !== 1'b0 || v1 !== 1'b0)) bad++;
      if (e == 8) check({tag, " k4 early v"}, v4, 1'b0);
      if (e == 9) begin
        check({tag, " k4 v"}, v4, 1'b1);
        check({tag, " k4 alu"}, alu4, exp);
      end
    end
    check({tag, " busy cycles"}, bad, 0);
    check({tag, " v1"}, v1, 1'b1);
    check({tag, " alu1"}, alu1, exp);
    check({tag, " zero1"}, z1, exp == 32'h0);
    check({tag, " tgt1"}, tgt1, 32'h210);
    check({tag, " rd1"}, rd1, 5'd7);
    check({tag, " rw1"}, rw1, 1'b1);
    check({tag, " rdy1"}, rdy1, 1'b1);
  endtask

  initial begin
    int bad;
    clear_in();
    step(); step();
    check("reset v1", v1, 1'b0);
    check("reset alu1", alu1, 32'h0);
    check("reset tgt1", tgt1, 32'h0);
    check("reset rw1", rw1, 1'b0);
    reset = 0;
    check("reset rdy1", rdy1, 1'b1);

    alu_op(ALU_ADD, 1'b0, SRC2_REG2, 32'd5, 32'd7, 32'h20);
    step();
    check("add v1", v1, 1'b1);
    check("add alu1", alu1, 32'd12);
    check("add zero1", z1, 1'b0);
    check("add tgt1", tgt1, 32'h120);
    check("add rd1", rd1, 5'd9);
    check("add r2o1", r2o1, 32'd7);

    alu_op(ALU_SUB, 1'b0, SRC2_IMM, 32'd7, 32'd0, 32'd7);
    i_stall = 1;
    step(); step(); step();
    check("stall v1", v1, 1'b1);
    check("stall alu1", alu1, 32'd12);
    check("stall rw1", rw1, 1'b1);
    check("stall rdy1", rdy1, 1'b0);
    i_stall = 0; i_valid = 0;
    step();
    check("bubble v1", v1, 1'b0);
    check("bubble rw1", rw1, 1'b0);

    alu_op(ALU_SUB, 1'b0, SRC2_IMM, 32'd7, 32'd0, 32'd7);
    step();
    check("sub alu1", alu1, 32'd0);
    check("sub zero1", z1, 1'b1);
    alu_op(ALU_ADD, 1'b1, SRC2_FOUR, 32'd99, 32'd0, 32'h40);
    jump = 1;
    step();
    check("jal alu1", alu1, 32'h104);
    check("jal jp1", jp1, 1'b1);
    check("jal tgt1", tgt1, 32'h140);
    alu_op(ALU_SRA, 1'b0, SRC2_IMM, 32'h80000000, 32'd0, 32'd4);
    step();
    check("sra alu1", alu1, 32'hF8000000);
    alu_op(ALU_SLT, 1'b0, SRC2_REG2, 32'hFFFFFFFF, 32'd1, 32'd0);
    step();
    check("slt alu1", alu1, 32'd1);

    alu_op(ALU_ADD, 1'b0, SRC2_REG2, 32'd1, 32'd2, 32'd0);
    i_flush = 1;
    step();
    check("flush in v1", v1, 1'b0);
    check("flush in rw1", rw1, 1'b0);
    check("flush in rdy1", rdy1, 1'b1);
    i_flush = 0;
    step();
    check("post flush v1", v1, 1'b1);
    check("post flush alu1", alu1, 32'd3);
    clear_in();
    i_stall = 1; i_flush = 1;
    step();
    check("flush stall v1", v1, 1'b0);
    check("flush stall rw1", rw1, 1'b0);
    clear_in();

    mul_test("mulhu", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 32'hFFFFFFFE);
    mul_test("mul", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000001);
    mul_test("mulh", 32'hFFFFFFFD, 32'd4, 2'b11, 32'hFFFFFFFF);
    mul_test("muls lo", 32'hFFFFFFFD, 32'd4, 2'b10, 32'hFFFFFFF4);
    mul_test("mul zero", 32'h00010000, 32'h00010000, 2'b00, 32'h0);

    clear_in();
    i_valid = 1; mulen = 1; r1 = 32'd6; r2 = 32'd7; regwr = 1;
    step();
    clear_in();
    for (int e = 1; e <= 32; e++) step();
    i_stall = 1;
    step(); step(); step();
    check("mstall v1", v1, 1'b0);
    check("mstall rdy1", rdy1, 1'b0);
    i_stall = 0;
    step();
    check("mstall out v1", v1, 1'b1);
    check("mstall out alu1", alu1, 32'd42);

    clear_in();
    i_valid = 1; mulen = 1; r1 = 32'h0000FFFF; r2 = 32'h0000FFFF; regwr = 1;
    step();
    clear_in();
    for (int e = 1; e <= 22; e++) step();
    i_flush = 1;
    step();
    i_flush = 0;
    check("mflush v1", v1, 1'b0);
    check("mflush rdy1", rdy1, 1'b1);
    bad = 0;
    for (int e = 0; e < 40; e++) begin
      step();
      if (v1 !== 1'b0) bad++;
    end
    check("mflush no result", bad, 0);

    alu_op(ALU_ADD, 1'b0, SRC2_REG2, 32'd5, 32'd7, 32'h20);
    step();
    clear_in();
    i_valid = 1; mulen = 1; r1 = 32'd3; r2 = 32'd3; regwr = 1; regdst = 5'd4;
    step();
    clear_in();
    step(); step(); step(); step(); step();
    reset = 1;
    #1;
    check("arst alu1", alu1, 32'h0);
    check("arst tgt1", tgt1, 32'h0);
    check("arst rd1", rd1, 5'd0);
    check("arst alu4", alu4, 32'h0);
    step();
    reset = 0;
    bad = 0;
    for (int e = 0; e < 40; e++) begin
      step();
      if (v1 !== 1'b0) bad++;
    end
    check("arst no result", bad, 0);

`ifdef EXEC_FWD_EN
    alu_op(ALU_ADD, 1'b0, SRC2_IMM, 32'h11, 32'h22, 32'd0);
    rs1 = 5'd3; rs2 = 5'd3; mem_dst = 5'd3; mem_we = 1; mem_data = 32'hAA;
    wb_dst = 5'd3; wb_we = 1; wb_data = 32'hBB;
    step();
    check("fwd mem alu1", alu1, 32'hAA);
    check("fwd mem r2o1", r2o1, 32'hAA);
    mem_dst = 5'd8;
    step();
    check("fwd wb alu1", alu1, 32'hBB);
    rs1 = 5'd0; mem_dst = 5'd0; wb_dst = 5'd0;
    step();
    check("fwd x0 alu1", alu1, 32'h11);
    clear_in();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
